// File: rtl/pulse_period_meter.sv
// Pulse period meter: reports the spacing between successive pulse_in events in enabled clock cycles.
// Define PULSE_PERIOD_EDGE_DETECT_EN to count rising edges of pulse_in instead of high levels.

module adder_n #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_sum
);
  assign o_sum = i_a + i_b;
endmodule

module comparator_eq #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic         o_eq
);
  assign o_eq = (i_a == i_b);
endmodule

module pulse_period_meter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         pulse_in,
  output logic [N-1:0] period,
  output logic         valid,
  output logic         overflow,
  output logic         armed
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_COUNT = 2'b01,
    S_SAT   = 2'b10
  } state_t;

  localparam logic [N-1:0] ONE      = N'(1);
  localparam logic [N-1:0] ALL_ONES = '1;

  state_t       r_state, w_state_nxt;
  logic [N-1:0] r_counter, w_counter_nxt;
  logic [N-1:0] r_period, w_period_nxt;
  logic         r_valid, w_valid_nxt;
  logic         r_overflow, w_overflow_nxt;
  logic         r_armed, w_armed_nxt;
  logic [N-1:0] w_counter_inc;
  logic         w_at_max;
  logic         w_event;

`ifdef PULSE_PERIOD_EDGE_DETECT_EN
  logic r_pulse_prev;

  // Previous sample only advances on enabled cycles, so a high level spanning
  // a disabled gap is still one edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_pulse_prev <= 1'b0;
    else if (ena) r_pulse_prev <= pulse_in;
  end

  assign w_event = ena & pulse_in & ~r_pulse_prev;
`else
  assign w_event = ena & pulse_in;
`endif

  adder_n #(.N(N)) u_counter_inc (
    .i_a   (r_counter),
    .i_b   (ONE),
    .o_sum (w_counter_inc)
  );

  comparator_eq #(.N(N)) u_counter_at_max (
    .i_a  (r_counter),
    .i_b  (ALL_ONES),
    .o_eq (w_at_max)
  );

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_counter  <= ONE;
      r_period   <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_counter  <= w_counter_nxt;
      r_period   <= w_period_nxt;
      r_valid    <= w_valid_nxt;
      r_overflow <= w_overflow_nxt;
      r_armed    <= w_armed_nxt;
    end
  end

  always_comb begin
    // NOTE: defaults first on every path so no latch can be inferred.
    w_state_nxt    = r_state;
    w_counter_nxt  = r_counter;
    w_period_nxt   = r_period;
    w_overflow_nxt = r_overflow;
    w_armed_nxt    = r_armed;
    w_valid_nxt    = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_counter_nxt = ONE;
        if (w_event) begin
          w_state_nxt = S_COUNT;
          w_armed_nxt = 1'b1;
        end
      end
      S_COUNT: begin
        if (w_event) begin
          w_period_nxt   = r_counter;
          w_overflow_nxt = 1'b0;
          w_valid_nxt    = 1'b1;
          w_counter_nxt  = ONE;
        end else if (ena) begin
          // An event on the max-count cycle is still in range; saturate only after it passes.
          if (w_at_max) w_state_nxt = S_SAT;
          else          w_counter_nxt = w_counter_inc;
        end
      end
      S_SAT: begin
        if (w_event) begin
          w_period_nxt   = ALL_ONES;
          w_overflow_nxt = 1'b1;
          w_valid_nxt    = 1'b1;
          w_counter_nxt  = ONE;
          w_state_nxt    = S_COUNT;
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_counter_nxt = ONE;
      end
    endcase
  end

  assign period   = r_period;
  assign valid    = r_valid;
  assign overflow = r_overflow;
  assign armed    = r_armed;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Testbench for pulse_period_meter: N=8 and N=4 instances share stimulus and are
// compared every cycle against an event-interval reference model.

module tb_pulse_period_meter;

  logic       clk;
  logic       rst;
  logic       ena;
  logic       pulse_in;
  logic [7:0] period8;
  logic       valid8, ovf8, armed8;
  logic [3:0] period4;
  logic       valid4, ovf4, armed4;

  int total = 0;
  int bad   = 0;

`ifdef PULSE_PERIOD_EDGE_DETECT_EN
  localparam bit LEVEL_MODE = 1'b0;
`else
  localparam bit LEVEL_MODE = 1'b1;
`endif

  pulse_period_meter #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .ena(ena), .pulse_in(pulse_in),
    .period(period8), .valid(valid8), .overflow(ovf8), .armed(armed8)
  );

  pulse_period_meter #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .ena(ena), .pulse_in(pulse_in),
    .period(period4), .valid(valid4), .overflow(ovf4), .armed(armed4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: count enabled cycles, remember the index of the last event,
  // and report the distance between events clipped to the counter range.
  int unsigned en_idx, last_idx, m_gap;
  logic        m_armed, m_valid, m_event;
  logic [7:0]  m8_period;
  logic        m8_ovf;
  logic [3:0]  m4_period;
  logic        m4_ovf;

  assign m_gap = en_idx - last_idx;

`ifdef PULSE_PERIOD_EDGE_DETECT_EN
  logic m_prev;
  always @(posedge clk or negedge rst) begin
    if (!rst)     m_prev <= 1'b0;
    else if (ena) m_prev <= pulse_in;
  end
  assign m_event = ena && pulse_in && !m_prev;
`else
  assign m_event = ena && pulse_in;
`endif

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_idx <= 0; last_idx <= 0; m_armed <= 1'b0; m_valid <= 1'b0;
      m8_period <= '0; m8_ovf <= 1'b0; m4_period <= '0; m4_ovf <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      if (ena) en_idx <= en_idx + 1;
      if (m_event) begin
        last_idx <= en_idx;
        m_armed  <= 1'b1;
        if (m_armed) begin
          m_valid   <= 1'b1;
          m8_period <= (m_gap > 255) ? 8'hFF : m_gap[7:0];
          m8_ovf    <= (m_gap > 255);
          m4_period <= (m_gap > 15) ? 4'hF : m_gap[3:0];
          m4_ovf    <= (m_gap > 15);
        end
      end
    end
  end

  logic [10:0] obs8, exp8;
  logic [6:0]  obs4, exp4;
  assign obs8 = {armed8, valid8, ovf8, period8};
  assign exp8 = {m_armed, m_valid, m8_ovf, m8_period};
  assign obs4 = {armed4, valid4, ovf4, period4};
  assign exp4 = {m_armed, m_valid, m4_ovf, m4_period};

  // Apply inputs for one cycle and return 1 time unit after the sampling edge.
  task automatic step(input logic e, input logic p);
    ena      = e;
    pulse_in = p;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b0; pulse_in = 1'b0;
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1);
      total++;
      if (obs8 !== 11'd0) begin bad++; $display("FAIL reset_n8 cyc=%0d got=%h want=0", i, obs8); end
      total++;
      if (obs4 !== 7'd0) begin bad++; $display("FAIL reset_n4 cyc=%0d got=%h want=0", i, obs4); end
    end
    rst = 1'b1;
  endtask

  task automatic test_pulse_pair();
    for (int t = 0; t <= 20; t++) begin
      step(1'b1, (t == 10) || (t == 15));
      total++;
      if (obs8 !== exp8) begin bad++; $display("FAIL pair_model_n8 t=%0d got=%h want=%h", t, obs8, exp8); end
      if (t == 10) begin
        total++;
        if ({armed8, valid8} !== 2'b10) begin
          bad++; $display("FAIL pair_arm t=%0d got armed/valid=%b%b want=10", t, armed8, valid8);
        end
      end
      if (t == 15) begin
        total++;
        if ({valid8, ovf8, period8} !== {1'b1, 1'b0, 8'd5}) begin
          bad++; $display("FAIL pair_period got v=%b o=%b p=%0d want v=1 o=0 p=5", valid8, ovf8, period8);
        end
      end
    end
  endtask

  task automatic test_loopback(input int ticks);
    int last_v;
    last_v = -1;
    step(1'b1, 1'b0);
    for (int i = 0; i < ticks * 8; i++) begin
      step(1'b1, (i % ticks) == 0);
      total++;
      if (obs8 !== exp8) begin bad++; $display("FAIL loop%0d_model_n8 i=%0d got=%h want=%h", ticks, i, obs8, exp8); end
      total++;
      if (obs4 !== exp4) begin bad++; $display("FAIL loop%0d_model_n4 i=%0d got=%h want=%h", ticks, i, obs4, exp4); end
      if (i > 0 && !(ticks == 1 && !LEVEL_MODE)) begin
        total++;
        if (valid8 && period8 !== 8'(ticks)) begin
          bad++; $display("FAIL loop%0d_period i=%0d got=%0d want=%0d", ticks, i, period8, ticks);
        end
        if (valid8) begin
          if (last_v >= 0) begin
            total++;
            if (i - last_v != ticks) begin
              bad++; $display("FAIL loop%0d_spacing i=%0d got=%0d want=%0d", ticks, i, i - last_v, ticks);
            end
          end
          last_v = i;
        end
      end
    end
  endtask

  task automatic test_saturation();
    int gaps[5]    = '{20, 15, 16, 255, 256};
    int want_p8[5] = '{20, 15, 16, 255, 255};
    int want_o8[5] = '{0, 0, 0, 0, 1};
    int want_o4[5] = '{1, 0, 1, 1, 1};
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    for (int g = 0; g < 5; g++) begin
      for (int c = 1; c <= gaps[g]; c++) begin
        step(1'b1, c == gaps[g]);
        total++;
        if (obs4 !== exp4) begin bad++; $display("FAIL sat_model_n4 gap=%0d c=%0d got=%h want=%h", gaps[g], c, obs4, exp4); end
        total++;
        if (obs8 !== exp8) begin bad++; $display("FAIL sat_model_n8 gap=%0d c=%0d got=%h want=%h", gaps[g], c, obs8, exp8); end
      end
      total++;
      if ({valid4, ovf4, period4} !== {1'b1, 1'(want_o4[g]), 4'hF}) begin
        bad++; $display("FAIL sat_n4 gap=%0d got v=%b o=%b p=%0d want v=1 o=%0d p=15", gaps[g], valid4, ovf4, period4, want_o4[g]);
      end
      total++;
      if ({valid8, ovf8, period8} !== {1'b1, 1'(want_o8[g]), 8'(want_p8[g])}) begin
        bad++; $display("FAIL sat_n8 gap=%0d got v=%b o=%b p=%0d want v=1 o=%0d p=%0d", gaps[g], valid8, ovf8, period8, want_o8[g], want_p8[g]);
      end
    end
  endtask

  task automatic test_ena_gating();
    logic ev[12] = '{1, 1, 1, 0, 0, 1, 0, 0, 1, 1, 1, 1};
    logic pl[12] = '{1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0};
    step(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(ev[i], pl[i]);
      total++;
      if (obs8 !== exp8) begin bad++; $display("FAIL gate_model_n8 i=%0d got=%h want=%h", i, obs8, exp8); end
      if (i == 10) begin
        total++;
        if ({valid8, ovf8, period8} !== {1'b1, 1'b0, 8'd6}) begin
          bad++; $display("FAIL gate_period got v=%b o=%b p=%0d want v=1 o=0 p=6", valid8, ovf8, period8);
        end
      end
      if (i == 4 || i == 7) begin
        total++;
        if (valid8 !== 1'b0) begin bad++; $display("FAIL gate_valid_low i=%0d got=%b want=0", i, valid8); end
      end
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    #2 rst = 1'b0;
    #1;
    total++;
    if (obs8 !== 11'd0) begin bad++; $display("FAIL areset_clear got=%h want=0", obs8); end
    total++;
    if (obs4 !== exp4) begin bad++; $display("FAIL areset_model_n4 got=%h want=%h", obs4, exp4); end
    step(1'b1, 1'b1);
    rst = 1'b1;
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    total++;
    if ({armed8, valid8} !== 2'b10) begin bad++; $display("FAIL areset_rearm got armed/valid=%b%b want=10", armed8, valid8); end
    for (int i = 0; i < 9; i++) begin
      step(1'b1, i == 8);
      total++;
      if (obs8 !== exp8) begin bad++; $display("FAIL areset_model_n8 i=%0d got=%h want=%h", i, obs8, exp8); end
    end
    total++;
    if ({valid8, ovf8, period8} !== {1'b1, 1'b0, 8'd9}) begin
      bad++; $display("FAIL areset_period got v=%b o=%b p=%0d want v=1 o=0 p=9", valid8, ovf8, period8);
    end
  endtask

  task automatic test_back_to_back();
    int nval;
    int last_p;
    nval   = 0;
    last_p = 0;
    #2 rst = 1'b0;
    step(1'b0, 1'b0);
    rst = 1'b1;
    for (int t = 0; t <= 22; t++) begin
      step(1'b1, (t >= 10 && t <= 12) || t == 18);
      total++;
      if (obs8 !== exp8) begin bad++; $display("FAIL b2b_model_n8 t=%0d got=%h want=%h", t, obs8, exp8); end
      if (valid8) begin
        nval++;
        last_p = int'(period8);
      end
    end
    total++;
    if (nval != (LEVEL_MODE ? 3 : 1)) begin
      bad++; $display("FAIL b2b_count got=%0d want=%0d", nval, LEVEL_MODE ? 3 : 1);
    end
    total++;
    if (last_p != (LEVEL_MODE ? 6 : 8)) begin
      bad++; $display("FAIL b2b_last_period got=%0d want=%0d", last_p, LEVEL_MODE ? 6 : 8);
    end
  endtask

  task automatic test_random();
    int density;
    density = 2;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        case ($urandom_range(0, 2))
          0:       density = 2;
          1:       density = 12;
          default: density = 300;
        endcase
      end
      if ($urandom_range(0, 599) == 0) begin
        #2 rst = 1'b0;
        #1;
        total++;
        if (obs8 !== 11'd0) begin bad++; $display("FAIL rand_reset i=%0d got=%h want=0", i, obs8); end
        step(1'b1, 1'b0);
        rst = 1'b1;
      end
      step(($urandom_range(0, 7) != 0), ($urandom_range(0, density - 1) == 0));
      total++;
      if (obs8 !== exp8) begin bad++; $display("FAIL rand_model_n8 i=%0d got=%h want=%h", i, obs8, exp8); end
      total++;
      if (obs4 !== exp4) begin bad++; $display("FAIL rand_model_n4 i=%0d got=%h want=%h", i, obs4, exp4); end
    end
  endtask

  initial begin
    test_reset();
    test_pulse_pair();
    test_loopback(7);
    test_loopback(1);
    test_saturation();
    test_ena_gating();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
